// File: rtl/demux3to6_pkg.sv
// Shared encodings for the 3-wire to 6-bit half-word reassembler.
package demux3to6_pkg;

    typedef enum logic {
        WAIT_FIRST  = 1'b0,
        WAIT_SECOND = 1'b1
    } state_t;

    localparam logic SEL_FIRST  = 1'b0;
    localparam logic SEL_SECOND = 1'b1;

endpackage

// File: rtl/demux3to6_reg3_en.sv
// 3-bit register with synchronous active-high reset and load enable.
module reg3_en (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] d,
    output logic [2:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 3'b000;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/demux3to6.sv
// Reassembles two 3-bit half-words from a shared lane into a registered 6-bit word.
//   state       | meaning
//   WAIT_FIRST  | idle, expecting the sel=0 half (A,B,C)
//   WAIT_SECOND | first half held, expecting the sel=1 half (D,E,F)
module demux3to6
    import demux3to6_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0,
    input  logic             in1,
    input  logic             in2,
    input  logic             sel,
    input  logic             in_valid,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             D,
    output logic             E,
    output logic             F,
    output logic             out_valid,
    output logic             seq_err,
    output logic [CNT_W-1:0] pair_cnt
);

    state_t     state;
    state_t     state_nxt;
    logic       first_ld;
    logic       word_ld;
    logic       err_d;
    logic [2:0] lane;
    logic [2:0] first_q;
    logic [2:0] abc_q;
    logic [2:0] def_q;

    assign lane = {in0, in1, in2};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_FIRST;
            out_valid <= 1'b0;
            seq_err   <= 1'b0;
            pair_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= word_ld;
            seq_err   <= err_d;
            if (word_ld) begin
                pair_cnt <= pair_cnt + 1'b1;
            end
        end
    end

    // A repeated first half replaces the held one; an orphan second half is dropped.
    always_comb begin
        state_nxt = state;
        first_ld  = 1'b0;
        word_ld   = 1'b0;
        err_d     = 1'b0;
        if (in_valid) begin
            case (state)
                WAIT_FIRST: begin
                    if (sel == SEL_FIRST) begin
                        first_ld  = 1'b1;
                        state_nxt = WAIT_SECOND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                WAIT_SECOND: begin
                    if (sel == SEL_SECOND) begin
                        word_ld   = 1'b1;
                        state_nxt = WAIT_FIRST;
                    end else begin
                        err_d    = 1'b1;
                        first_ld = 1'b1;
                    end
                end
                default: state_nxt = WAIT_FIRST;
            endcase
        end
    end

    reg3_en u_first (.clk(clk), .rst(rst), .en(first_ld), .d(lane),    .q(first_q));
    reg3_en u_abc   (.clk(clk), .rst(rst), .en(word_ld),  .d(first_q), .q(abc_q));
    reg3_en u_def   (.clk(clk), .rst(rst), .en(word_ld),  .d(lane),    .q(def_q));

    assign {A, B, C} = abc_q;
    assign {D, E, F} = def_q;

endmodule

// File: doc/demux3to6.md
DEMUX3TO6 -- requirements
Module: demux3to6

Interface
REQ-001 Parameter: CNT_W, default 4, width of the completed-pair counter.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: in0, in1, in2  input  1 each  shared 3-wire lane carrying one half-word per beat.
REQ-005 Port: sel  input  1  half indicator: 0 = first group (A,B,C), 1 = second group (D,E,F).
REQ-006 Port: in_valid  input  1  beat qualifier; in0..in2 and sel are ignored when low.
REQ-007 Port: A, B, C, D, E, F  output  1 each  registered reassembled 6-bit word; A/D from in0, B/E from in1, C/F from in2.
REQ-008 Port: out_valid  output  1  one-cycle pulse: a complete, new A..F word is present.
REQ-009 Port: seq_err  output  1  one-cycle pulse: protocol ordering violation on this beat.
REQ-010 Port: pair_cnt  output  CNT_W  count of completed pairs since reset.

Function
REQ-011 Two states: WAIT_FIRST (expecting sel=0) and WAIT_SECOND (first half held, expecting sel=1).
REQ-012 WAIT_FIRST, in_valid=1, sel=0: capture in0..in2 into internal first-half register; go WAIT_SECOND; outputs unchanged.
REQ-013 WAIT_SECOND, in_valid=1, sel=1: load A,B,C from first-half register and D,E,F from in0..in2 in the same edge; out_valid=1 next cycle; pair_cnt increments; go WAIT_FIRST.
REQ-014 Latency: out_valid and new A..F appear on the edge that samples the second beat (registered, 1 cycle after beat presented).
REQ-015 A..F hold their last completed value until the next completed pair; never partially updated.
REQ-016 WAIT_FIRST, in_valid=1, sel=1 (orphan second half): beat discarded; seq_err pulses; state stays WAIT_FIRST; A..F, pair_cnt unchanged.
REQ-017 WAIT_SECOND, in_valid=1, sel=0 (repeated first half): seq_err pulses; first-half register overwritten with new beat; state stays WAIT_SECOND.
REQ-018 in_valid=0: no state change, no pulses; gaps of any length between halves are legal.
REQ-019 out_valid and seq_err never assert in the same cycle; each is low in every cycle not explicitly pulsed.
REQ-020 pair_cnt wraps modulo 2^CNT_W (all-ones + 1 -> 0) without error indication.

Reset
REQ-021 rst=1 at a rising edge: state=WAIT_FIRST; A..F=0; first-half register=0; out_valid=0; seq_err=0; pair_cnt=0.
REQ-022 rst has priority over any beat in the same cycle; a first half held at reset is discarded, so a following sel=1 beat yields seq_err.
REQ-023 Outputs are undefined only before the first reset edge.

Structure
REQ-024 Shared package holds state encoding (WAIT_FIRST=0, WAIT_SECOND=1) and constants SEL_FIRST=0, SEL_SECOND=1.
REQ-025 One sub-module, reg3_en: 3-bit register with synchronous active-high reset and load enable; instantiated for first-half, A..C and D..F.
REQ-026 Output side forms the inverse of the existing 6-to-3 selector: driven by it with sel toggled per beat, A..F reproduce its six inputs.

Verification
REQ-027 Reset then beats (sel=0, in=101), (sel=1, in=011) -> next cycle A,B,C=1,0,1, D,E,F=0,1,1, out_valid=1 one cycle, pair_cnt=1.
REQ-028 Beat sel=1 in WAIT_FIRST -> seq_err=1 one cycle, A..F stay 0, pair_cnt stays 0.
REQ-029 sel=0 in=111, sel=0 in=010, sel=1 in=000 -> seq_err on 2nd beat; output A,B,C=0,1,0, D,E,F=0,0,0, out_valid=1.
REQ-030 sel=0 beat, 5 idle cycles (in_valid=0), sel=1 beat -> single out_valid, correct word, no seq_err.
REQ-031 sel=0 beat, rst=1 for one cycle, sel=1 beat -> seq_err=1, no out_valid, pair_cnt=0.
REQ-032 CNT_W=4, 17 back-to-back valid pairs -> pair_cnt sequence reaches 15, wraps to 0, ends at 1; out_valid pulses 17 times.
